// File: rtl/im2col_ch_sequencer.sv
// Channel-loop controller for the Im2Col input unit: walks one convolution job
// channel by channel, pulsing start per channel and waiting for the unit to finish.
module im2col_ch_sequencer #(
  parameter int CH_W   = 7,
  parameter int TO_W   = 12,
  parameter int TO_MAX = 4000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cfg_valid,
  output logic            o_cfg_ready,
  input  logic [CH_W-1:0] i_cfg_num_ch,
  input  logic            i_cfg_square,
  input  logic            i_cfg_stride,
  input  logic            i_abort,
  output logic            o_w_square,
  output logic            o_w_vector,
  output logic            o_stride,
  output logic [CH_W-1:0] o_current_ch,
  output logic            o_start,
  input  logic            i_started,
  input  logic            i_finish,
  input  logic            i_sa_ready,
  output logic            o_ch_done,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_STRT,
    ST_RUN,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_MAX - 1);

  state_t          state_reg;
  logic [CH_W-1:0] num_ch_reg;
  logic [TO_W-1:0] wd_reg;
  logic            finish_q_reg;
  logic            finish_rise;

  // A finish level carried over from the previous channel must not count.
  assign finish_rise = i_finish & ~finish_q_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      num_ch_reg   <= '0;
      wd_reg       <= '0;
      finish_q_reg <= 1'b0;
      o_cfg_ready  <= 1'b1;
      o_w_square   <= 1'b0;
      o_w_vector   <= 1'b0;
      o_stride     <= 1'b0;
      o_current_ch <= '0;
      o_start      <= 1'b0;
      o_ch_done    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      finish_q_reg <= i_finish;
      o_start      <= 1'b0;
      o_ch_done    <= 1'b0;
      o_done       <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            num_ch_reg   <= i_cfg_num_ch;
            o_current_ch <= '0;
            o_error      <= 1'b0;
            o_cfg_ready  <= 1'b0;
            o_busy       <= 1'b1;
            o_w_square   <= i_cfg_square;
            o_w_vector   <= ~i_cfg_square;
            o_stride     <= i_cfg_stride;
            if (i_cfg_num_ch == '0) begin
              state_reg <= ST_FIN;
              o_done    <= 1'b1;
            end else begin
              state_reg <= ST_LAUNCH;
            end
          end
        end

        ST_LAUNCH: begin
          if (i_abort) begin
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else if (i_sa_ready) begin
            o_start   <= 1'b1;
            wd_reg    <= '0;
            state_reg <= ST_WAIT_STRT;
          end
        end

        ST_WAIT_STRT: begin
          if (i_abort) begin
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else if (i_started) begin
            state_reg <= ST_RUN;
          end else if (wd_reg == WD_LAST) begin
            o_error   <= 1'b1;
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else begin
            wd_reg <= wd_reg + TO_W'(1);
          end
        end

        ST_RUN: begin
          if (i_abort) begin
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else if (finish_rise) begin
            o_ch_done <= 1'b1;
            state_reg <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (i_abort) begin
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else if (o_current_ch == num_ch_reg - CH_W'(1)) begin
            state_reg <= ST_FIN;
            o_done    <= 1'b1;
          end else begin
            o_current_ch <= o_current_ch + CH_W'(1);
            state_reg    <= ST_LAUNCH;
          end
        end

        ST_FIN: begin
          // Busy stays high through FIN; mode outputs return to 0 for IDLE.
          state_reg    <= ST_IDLE;
          o_busy       <= 1'b0;
          o_cfg_ready  <= 1'b1;
          o_w_square   <= 1'b0;
          o_w_vector   <= 1'b0;
          o_stride     <= 1'b0;
          o_current_ch <= '0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im2col_ch_sequencer.sv
// Scoreboard bench for im2col_ch_sequencer: jobs push expected events, a monitor
// pops and compares them (kind, channel, timing) whenever the DUT emits one.
module tb_im2col_ch_sequencer;
  localparam int CH_W   = 7;
  localparam int TO_W   = 12;
  localparam int TO_MAX = 16;
  localparam int HIST   = 65536;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_cfg_valid;
  logic            o_cfg_ready;
  logic [CH_W-1:0] i_cfg_num_ch;
  logic            i_cfg_square;
  logic            i_cfg_stride;
  logic            i_abort;
  logic            o_w_square;
  logic            o_w_vector;
  logic            o_stride;
  logic [CH_W-1:0] o_current_ch;
  logic            o_start;
  logic            i_started;
  logic            i_finish;
  logic            i_sa_ready;
  logic            o_ch_done;
  logic            o_busy;
  logic            o_done;
  logic            o_error;

  im2col_ch_sequencer #(.CH_W(CH_W), .TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_num_ch(i_cfg_num_ch), .i_cfg_square(i_cfg_square), .i_cfg_stride(i_cfg_stride),
    .i_abort(i_abort),
    .o_w_square(o_w_square), .o_w_vector(o_w_vector), .o_stride(o_stride),
    .o_current_ch(o_current_ch), .o_start(o_start),
    .i_started(i_started), .i_finish(i_finish), .i_sa_ready(i_sa_ready),
    .o_ch_done(o_ch_done), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // kind: 0 start, 1 ch_done, 2 done; tag (done only): 0 normal, 1 watchdog, 2 abort
  typedef struct {
    int kind;
    int ch;
    int err;
    int tag;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int failures = 0;

  bit sa_hist [HIST];
  int sa_mode = 0;
  int start_dly_fix = -1;
  int fin_dly_fix = -1;
  bit hold_en = 1'b1;
  int no_start_ch = -1;
  bit exp_sq = 1'b0;
  bit exp_st = 1'b0;
  bit last_err = 1'b0;
  int mark_cyc = 0;
  int last_start_cyc = 0;
  int fin_rise_cyc = 0;
  int abort_cyc = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_job(int num, int to_ch, int abort_ch);
    ev_t e;
    for (int ch = 0; ch < num; ch++) begin
      e = '{0, ch, 0, 0};
      exp_q.push_back(e);
      if (ch == to_ch) begin
        e = '{2, 0, 1, 1};
        exp_q.push_back(e);
        return;
      end
      if (ch == abort_ch) begin
        e = '{2, 0, 0, 2};
        exp_q.push_back(e);
        return;
      end
      e = '{1, ch, 0, 0};
      exp_q.push_back(e);
    end
    e = '{2, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  task automatic handle_ev(int kind);
    ev_t e;
    int expc;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    if (kind == 0) begin
      check("start_ch", int'(o_current_ch), e.ch);
      // start follows the first LAUNCH cycle that saw sa_ready high
      expc = -1;
      for (int k = mark_cyc + 1; k < cyc && k < HIST; k++) begin
        if (sa_hist[k]) begin
          expc = k + 1;
          break;
        end
      end
      check("start_time", cyc, expc);
      last_start_cyc = cyc;
    end else if (kind == 1) begin
      check("ch_done_ch", int'(o_current_ch), e.ch);
      check("ch_done_time", cyc, fin_rise_cyc + 1);
      mark_cyc = cyc;
    end else begin
      if (e.tag == 0) expc = mark_cyc + 1;
      else if (e.tag == 1) expc = last_start_cyc + TO_MAX;
      else expc = abort_cyc + 1;
      check("done_time", cyc, expc);
      check("done_error", int'(o_error), e.err);
      check("done_busy", int'(o_busy), 1);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (i_cfg_valid && o_cfg_ready) mark_cyc = cyc;
        if (o_busy)
          check("modes_busy", int'({o_w_square, o_w_vector, o_stride}),
                int'({exp_sq, ~exp_sq, exp_st}));
        else
          check("modes_idle", int'({o_w_square, o_w_vector, o_stride}), 0);
        if (o_start) handle_ev(0);
        if (o_ch_done) handle_ev(1);
        if (o_done) handle_ev(2);
      end
    end
  end

  // Systolic-array readiness driver; mode 2 drops ready for 5 cycles after the first ch_done
  initial begin
    int low;
    bit armed;
    low = 0;
    armed = 1'b1;
    i_sa_ready = 1'b1;
    forever begin
      tick();
      if (sa_mode != 2) armed = 1'b1;
      if (low > 0) begin
        i_sa_ready = 1'b0;
        low--;
      end else if (sa_mode == 2 && armed && o_ch_done) begin
        armed = 1'b0;
        low = 5;
        i_sa_ready = 1'b1;
      end else if (sa_mode == 1) begin
        i_sa_ready = ($urandom % 4) != 0;
      end else begin
        i_sa_ready = 1'b1;
      end
      if (cyc < HIST) sa_hist[cyc] = i_sa_ready;
    end
  end

  // Input-unit responder: started after a delay, then a finish edge; finish may be held
  initial begin
    int sd;
    int fd;
    bit hold_now;
    i_started = 1'b0;
    i_finish = 1'b0;
    forever begin
      tick();
      if (o_start && !i_rst && int'(o_current_ch) != no_start_ch) begin
        sd = (start_dly_fix >= 0) ? start_dly_fix : int'($urandom_range(0, 3));
        fd = (fin_dly_fix >= 1) ? fin_dly_fix : int'($urandom_range(1, 12));
        hold_now = hold_en && ($urandom % 3 == 0);
        repeat (sd) tick();
        i_started = 1'b1;
        if (i_finish) begin
          repeat ($urandom_range(0, 3)) tick();
          i_finish = 1'b0;
        end
        repeat (fd) tick();
        i_finish = 1'b1;
        fin_rise_cyc = cyc;
        i_started = 1'b0;
        if (!hold_now) begin
          tick();
          i_finish = 1'b0;
        end
      end
    end
  end

  task automatic recover();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    repeat (50) tick();
  endtask

  task automatic run_job(int num, bit sq, bit st, int to_ch, int abort_ch);
    int w;
    bit seen;
    int ab_state;
    int ab_cnt;
    w = 0;
    while (!o_cfg_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_job", int'(o_cfg_ready), 1);
    check("error_sticky", int'(o_error), int'(last_err));
    no_start_ch = to_ch;
    exp_sq = sq;
    exp_st = st;
    push_job(num, to_ch, abort_ch);
    i_cfg_num_ch = CH_W'(num);
    i_cfg_square = sq;
    i_cfg_stride = st;
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    check("busy_after_accept", int'(o_busy), 1);
    check("ready_after_accept", int'(o_cfg_ready), 0);
    check("error_cleared", int'(o_error), 0);
    seen = o_done;
    ab_state = 0;
    ab_cnt = 0;
    for (int t = 0; t < 8000 && !seen; t++) begin
      tick();
      if (o_done) begin
        seen = 1'b1;
      end else begin
        // junk requests while busy must be ignored
        i_cfg_valid = o_busy ? 1'($urandom % 2) : 1'b0;
        i_cfg_num_ch = CH_W'($urandom);
        i_cfg_square = 1'($urandom);
        i_cfg_stride = 1'($urandom);
        if (abort_ch >= 0) begin
          if (ab_state == 0 && o_start && int'(o_current_ch) == abort_ch) begin
            ab_state = 1;
          end else if (ab_state == 1 && i_started) begin
            ab_state = 2;
            ab_cnt = 0;
          end else if (ab_state == 2) begin
            ab_cnt++;
            if (ab_cnt == 2) begin
              i_abort = 1'b1;
              abort_cyc = cyc;
              ab_state = 3;
            end
          end else if (ab_state == 3) begin
            i_abort = 1'b0;
            ab_state = 4;
          end
        end
      end
    end
    i_cfg_valid = 1'b0;
    i_abort = 1'b0;
    if (!seen) begin
      check("job_timeout", 0, 1);
      recover();
      return;
    end
    last_err = (to_ch >= 0 && to_ch < num);
    tick();
    check("busy_after_done", int'(o_busy), 0);
    check("ready_after_done", int'(o_cfg_ready), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int num;
    int to_ch;
    i_rst = 1'b1;
    i_cfg_valid = 1'b0;
    i_cfg_num_ch = '0;
    i_cfg_square = 1'b0;
    i_cfg_stride = 1'b0;
    i_abort = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;

    check("rst_cfg_ready", int'(o_cfg_ready), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_pulses", int'({o_start, o_ch_done, o_done}), 0);
    check("rst_error", int'(o_error), 0);
    check("rst_current_ch", int'(o_current_ch), 0);

    // abort while idle is ignored
    i_abort = 1'b1;
    repeat (2) tick();
    i_abort = 1'b0;
    check("idle_abort_ready", int'(o_cfg_ready), 1);
    check("idle_abort_busy", int'(o_busy), 0);

    start_dly_fix = 0;
    fin_dly_fix = 10;
    run_job(3, 1'b1, 1'b0, -1, -1);
    run_job(1, 1'b0, 1'b1, -1, -1);
    run_job(0, 1'b1, 1'b1, -1, -1);

    sa_mode = 2;
    run_job(3, 1'b1, 1'b1, -1, -1);
    sa_mode = 0;

    start_dly_fix = -1;
    fin_dly_fix = -1;
    run_job(2, 1'b0, 1'b0, 1, -1);
    run_job(2, 1'b1, 1'b0, -1, -1);

    start_dly_fix = 0;
    fin_dly_fix = 40;
    run_job(4, 1'b1, 1'b0, -1, 2);
    repeat (50) tick();

    // reset in the middle of a job
    fin_dly_fix = 20;
    no_start_ch = -1;
    exp_sq = 1'b0;
    exp_st = 1'b1;
    push_job(5, -1, -1);
    i_cfg_num_ch = CH_W'(5);
    i_cfg_square = 1'b0;
    i_cfg_stride = 1'b1;
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    repeat (30) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    check("midrst_ready", int'(o_cfg_ready), 1);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_pulses", int'({o_start, o_ch_done, o_done}), 0);
    check("midrst_current_ch", int'(o_current_ch), 0);
    last_err = 1'b0;
    repeat (50) tick();

    // widest channel count
    start_dly_fix = 0;
    fin_dly_fix = 1;
    run_job((1 << CH_W) - 1, 1'b0, 1'b0, -1, -1);

    start_dly_fix = -1;
    fin_dly_fix = -1;
    sa_mode = 1;
    for (int j = 0; j < 30; j++) begin
      num = $urandom_range(0, 6);
      to_ch = (num > 0 && ($urandom % 5 == 0)) ? int'($urandom_range(0, num - 1)) : -1;
      run_job(num, 1'($urandom), 1'($urandom), to_ch, -1);
    end
    sa_mode = 0;

    repeat (10) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
